// File: rtl/piece_sequencer_if.sv
// Piece request handshake between the game FSM and the piece sequencer.
//   piece_req  : game FSM asks for a piece (level, held until piece_ack)
//   piece_ack  : one-cycle pulse, piece_type valid and request consumed
//   piece_type : piece issued on the last ack
//   next_type  : preview of the next piece, valid while ready=1
//   ready      : preview valid and sequencer idle
interface piece_sequencer_if;
  localparam int unsigned TYPE_W = 3;

  logic              piece_req;
  logic              piece_ack;
  logic [TYPE_W-1:0] piece_type;
  logic [TYPE_W-1:0] next_type;
  logic              ready;

  // Game FSM side
  modport master (
    output piece_req,
    input  piece_ack,
    input  piece_type,
    input  next_type,
    input  ready
  );

  // Sequencer side
  modport slave (
    input  piece_req,
    output piece_ack,
    output piece_type,
    output next_type,
    output ready
  );
endinterface

// File: rtl/piece_sequencer.sv
// Piece sequencer: steps an external 8-bit LFSR and samples its low three
// bits to keep a one-deep preview of the next Tetris piece (0..6). Requests
// are served with a req/ack handshake, after which the preview is refilled.
// Code 7 is rejected, and so is a repeat of the issued piece on the first
// draw of a refill; the MAX_RETRY-th sample is always accepted (7 -> 0).
//   vclk      : clock, rising edge
//   rst       : asynchronous active-high reset
//   lfsr_val  : current LFSR register value
//   lfsr_step : step enable to the LFSR (high only in FILL_STEP)
//   pif       : piece handshake (slave side)
module piece_sequencer #(
  parameter int unsigned MAX_RETRY = 4
) (
  input  logic                vclk,
  input  logic                rst,
  input  logic [7:0]          lfsr_val,
  output logic                lfsr_step,
  piece_sequencer_if.slave    pif
);

  localparam int unsigned TYPE_W  = 3;
  localparam int unsigned RETRY_W = 4;
  localparam logic [TYPE_W-1:0]  BAD_CODE = TYPE_W'(7);
  localparam logic [RETRY_W-1:0] LAST_TRY = RETRY_W'(MAX_RETRY - 1);

  if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_param
    $error("piece_sequencer: MAX_RETRY must be in 1..15");
  end

  typedef enum logic [1:0] {
    FILL_STEP   = 2'd0,
    FILL_SAMPLE = 2'd1,
    IDLE        = 2'd2
  } state_e;

  state_e state;
  state_e state_nxt;

  logic [TYPE_W-1:0]  piece_type_q;
  logic [TYPE_W-1:0]  next_type_q;
  logic [RETRY_W-1:0] retry_cnt;
  logic               piece_ack_q;

  logic [TYPE_W-1:0]  cand;
  logic [TYPE_W-1:0]  cand_mapped;
  logic               last_try;
  logic               reject;

  // Combinational strobes from the output decoder
  logic               serve;
  logic               accept;
  logic               retry_inc;

  // Only the low three LFSR bits select a piece
  logic               unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr_val[7:TYPE_W];

  // Sample decision; the final try overrides every rejection rule
  assign cand        = lfsr_val[TYPE_W-1:0];
  assign cand_mapped = (cand == BAD_CODE) ? '0 : cand;
  assign last_try    = (retry_cnt == LAST_TRY);
  assign reject      = !last_try &&
                       ((cand == BAD_CODE) ||
                        ((retry_cnt == '0) && (cand == piece_type_q)));

  // State register
  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      state <= FILL_STEP;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL_STEP:   state_nxt = FILL_SAMPLE;
      FILL_SAMPLE: state_nxt = reject ? FILL_STEP : IDLE;
      IDLE:        state_nxt = pif.piece_req ? FILL_STEP : IDLE;
      default:     state_nxt = FILL_STEP;
    endcase
  end

  // Output decode; lfsr_step is masked so the LFSR never moves under reset
  always_comb begin
    lfsr_step = 1'b0;
    pif.ready = 1'b0;
    serve     = 1'b0;
    accept    = 1'b0;
    retry_inc = 1'b0;
    unique case (state)
      FILL_STEP: lfsr_step = !rst;
      FILL_SAMPLE: begin
        accept    = !reject;
        retry_inc = reject;
      end
      IDLE: begin
        pif.ready = 1'b1;
        serve     = pif.piece_req;
      end
      default: ;
    endcase
  end

  // Registered handshake outputs, preview and retry counter
  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      piece_type_q <= '0;
      next_type_q  <= '0;
      retry_cnt    <= '0;
      piece_ack_q  <= 1'b0;
    end else begin
      piece_ack_q <= serve;
      if (serve) begin
        piece_type_q <= next_type_q;
      end
      if (accept) begin
        next_type_q <= cand_mapped;
        retry_cnt   <= '0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + RETRY_W'(1);
      end
    end
  end

  assign pif.piece_ack  = piece_ack_q;
  assign pif.piece_type = piece_type_q;
  assign pif.next_type  = next_type_q;

endmodule

// File: tb/tb_piece_sequencer.sv
// Scoreboard bench for piece_sequencer: a bench-side LFSR (real XNOR 7/3
// or scripted values) feeds the DUT; expected acks and refills are queued
// at stimulus time and popped by a negedge monitor.
module tb_piece_sequencer;

  typedef struct packed {
    logic [2:0] nt;
    logic [7:0] steps;
  } fill_t;

  logic       vclk;
  logic       rst;
  logic [7:0] lfsr_q;
  logic       lfsr_step;
  logic       scripted;

  logic [7:0] script[$];
  logic [2:0] exp_ack[$];
  fill_t      exp_fill[$];

  int checks;
  int failures;

  // monitor state
  int  cyc;
  int  last_ack;
  bit  have_ack;
  bit  prev_ready;
  int  fill_cyc;
  int  step_cnt;
  int  v_step_idle;
  int  v_ack_order;
  int  v_spacing;

  piece_sequencer_if pif();

  piece_sequencer #(.MAX_RETRY(4)) dut (
    .vclk      (vclk),
    .rst       (rst),
    .lfsr_val  (lfsr_q),
    .lfsr_step (lfsr_step),
    .pif       (pif)
  );

  initial vclk = 1'b0;
  always #5 vclk = ~vclk;

  // LFSR model: XNOR taps 7/3, or scripted values (last one held)
  always @(posedge vclk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'h00;
    end else if (lfsr_step) begin
      if (scripted) begin
        if (script.size() != 0) lfsr_q <= script.pop_front();
      end else begin
        lfsr_q <= {lfsr_q[6:0], ~(lfsr_q[7] ^ lfsr_q[3])};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // Monitor / scoreboard
  always @(negedge vclk) begin
    fill_t      f;
    logic [2:0] e;
    if (rst) begin
      fill_cyc   = 0;
      step_cnt   = 0;
      prev_ready = 1'b0;
      have_ack   = 1'b0;
    end else begin
      cyc++;
      if (lfsr_step && pif.ready) v_step_idle++;
      if (pif.piece_ack) begin
        if (!prev_ready) v_ack_order++;
        if (have_ack && (cyc - last_ack) < 3) v_spacing++;
        have_ack = 1'b1;
        last_ack = cyc;
        if (exp_ack.size() == 0) begin
          fail_evt("unexpected_ack");
        end else begin
          e = exp_ack.pop_front();
          chk("ack_piece_type", 32'(pif.piece_type), 32'(e));
        end
        fill_cyc = 0;
        step_cnt = 0;
      end
      if (lfsr_step) step_cnt++;
      if (pif.ready && !prev_ready) begin
        if (exp_fill.size() == 0) begin
          fail_evt("unexpected_ready");
        end else begin
          f = exp_fill.pop_front();
          chk("fill_next_type", 32'(pif.next_type), 32'(f.nt));
          chk("fill_steps", 32'(step_cnt), 32'(f.steps));
          chk("fill_latency", 32'(fill_cyc), 32'(2 * int'(f.steps)));
        end
      end else if (!pif.ready) begin
        fill_cyc++;
      end
      prev_ready = pif.ready;
    end
  end

  task automatic do_req(input logic [2:0] e);
    bit got;
    got = 1'b0;
    exp_ack.push_back(e);
    pif.piece_req = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge vclk); #1;
      if (pif.piece_ack) got = 1'b1;
    end
    pif.piece_req = 1'b0;
    if (!got) fail_evt("req_timeout");
  endtask

  task automatic wait_ready();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge vclk); #1;
      if (pif.ready) got = 1'b1;
    end
    if (!got) fail_evt("ready_timeout");
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"},      32'(pif.ready), 32'd0);
    chk({tag, "_lfsr_step"},  32'(lfsr_step), 32'd0);
    chk({tag, "_piece_ack"},  32'(pif.piece_ack), 32'd0);
    chk({tag, "_piece_type"}, 32'(pif.piece_type), 32'd0);
    chk({tag, "_next_type"},  32'(pif.next_type), 32'd0);
  endtask

  initial begin
    int acks;
    checks = 0; failures = 0; cyc = 0; last_ack = 0;
    v_step_idle = 0; v_ack_order = 0; v_spacing = 0;
    rst = 1'b1; scripted = 1'b0; pif.piece_req = 1'b0;
    repeat (3) @(posedge vclk);
    #1;
    chk_reset_outs("reset");

    // Initial fill from real LFSR: 0x01 -> 1
    exp_fill.push_back('{3'd1, 8'd1});
    rst = 1'b0;
    wait_ready();

    // Serve 1, refill 0x03 -> 3
    exp_fill.push_back('{3'd3, 8'd1});
    do_req(3'd1);
    wait_ready();

    // Serve 3, refill 0x07, 0x0F rejected, 0x1E -> 6
    exp_fill.push_back('{3'd6, 8'd3});
    do_req(3'd3);
    wait_ready();

    // Serve 6, refill 0x3C -> 4
    exp_fill.push_back('{3'd4, 8'd1});
    do_req(3'd6);
    wait_ready();

    // LFSR stuck at 0xFF: four samples, last maps to 0
    scripted = 1'b1;
    script.push_back(8'hFF);
    exp_fill.push_back('{3'd0, 8'd4});
    do_req(3'd4);
    wait_ready();

    // Preview 2 via script
    script.push_back(8'h02);
    exp_fill.push_back('{3'd2, 8'd1});
    do_req(3'd0);
    wait_ready();

    // Duplicate of issued 2 rejected only on the first draw
    script.push_back(8'h02);
    script.push_back(8'h02);
    exp_fill.push_back('{3'd2, 8'd2});
    do_req(3'd2);
    wait_ready();

    // Reset during FILL_SAMPLE abandons the refill
    script.push_back(8'h05);
    do_req(3'd2);
    @(posedge vclk); #1;
    chk("t6_in_sample_step", 32'(lfsr_step), 32'd0);
    chk("t6_in_sample_ready", 32'(pif.ready), 32'd0);
    exp_fill.delete();
    rst = 1'b1;
    #1;
    chk_reset_outs("midfill_reset");

    // Request held from reset with the real LFSR: 1,3,6,4 then preview 0
    scripted = 1'b0;
    pif.piece_req = 1'b1;
    repeat (2) @(posedge vclk);
    #1;
    chk("held_req_in_reset_ack", 32'(pif.piece_ack), 32'd0);
    exp_fill.push_back('{3'd1, 8'd1});
    exp_fill.push_back('{3'd3, 8'd1});
    exp_fill.push_back('{3'd6, 8'd3});
    exp_fill.push_back('{3'd4, 8'd1});
    exp_fill.push_back('{3'd0, 8'd1});
    exp_ack.push_back(3'd1);
    exp_ack.push_back(3'd3);
    exp_ack.push_back(3'd6);
    exp_ack.push_back(3'd4);
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 200 && acks < 4; i++) begin
      @(posedge vclk); #1;
      if (pif.piece_ack) acks++;
    end
    pif.piece_req = 1'b0;
    chk("held_req_ack_count", 32'(acks), 32'd4);
    wait_ready();
    repeat (3) @(posedge vclk);
    #1;

    chk("pending_acks", 32'(exp_ack.size()), 32'd0);
    chk("pending_fills", 32'(exp_fill.size()), 32'd0);
    chk("step_in_idle", 32'(v_step_idle), 32'd0);
    chk("ack_without_ready", 32'(v_ack_order), 32'd0);
    chk("ack_spacing", 32'(v_spacing), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/piece_sequencer.md
Name: piece_sequencer

Overview:
- Controller that sequences the 8-bit LFSR to produce Tetris piece types (0..6) for the game FSM.
- Owns the LFSR's step enable and keeps a one-deep "next piece" preview register.
- Serves piece requests with a req/ack handshake, then refills the preview by stepping and sampling the LFSR.
- Rejects the invalid code 7 and, on the first draw only, a repeat of the piece just issued; a bounded retry count caps the refill time.

Parameters:
- MAX_RETRY, 4, number of LFSR samples per refill; the last sample is always accepted (range 1..15).

Ports:
- vclk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- piece_req  input  1  game FSM requests a new piece; level, held high until piece_ack
- lfsr_val  input  8  current LFSR output register
- lfsr_step  output  1  step enable to the LFSR (drives its new_block input)
- piece_ack  output  1  one-cycle pulse: piece_type is valid and the request is consumed
- piece_type  output  3  piece issued on the last ack
- next_type  output  3  preview of the next piece; valid while ready=1
- ready  output  1  preview valid and controller idle

Behaviour:
- Reset (asynchronous, any state): state=FILL_STEP, piece_type=0, next_type=0, retry_cnt=0, piece_ack=0.
- Reset outputs: ready=0, lfsr_step=0 while rst is held.
- States:
  - FILL_STEP: lfsr_step=1 for exactly this cycle. Next state is always FILL_SAMPLE.
  - FILL_SAMPLE: lfsr_step=0; cand=lfsr_val[2:0]. The LFSR has updated at the edge ending FILL_STEP.
  - IDLE: ready=1.
- Every output except ready and lfsr_step is registered. ready=(state==IDLE) and lfsr_step=(state==FILL_STEP) are decoded directly from the state register.
- Decision in FILL_SAMPLE:
  - Reject if cand==7, or if (retry_cnt==0 and cand==piece_type).
  - If retry_cnt==MAX_RETRY-1, accept unconditionally and map cand 7 to 0.
  - On accept: next_type<=cand (mapped), retry_cnt<=0, go to IDLE.
  - On reject: retry_cnt<=retry_cnt+1, go to FILL_STEP.
- In IDLE with piece_req=1 at an edge, all in the same edge: piece_type<=next_type, piece_ack<=1, state<=FILL_STEP. piece_ack clears on the following edge.
- Latency:
  - Request to ack: 1 cycle.
  - Ack to ready: 2 cycles minimum.
  - Ack to ready, worst case: 2*MAX_RETRY cycles.
- piece_req outside IDLE is not served and generates no lfsr_step. The request stays pending and is served on the first IDLE cycle.
- piece_req held high after ack is a new request, served at the next IDLE.
- piece_type changes only at ack. next_type changes only on accept in FILL_SAMPLE.
- The duplicate check after reset uses piece_type=0, so cand 0 on the first draw is rejected.
- An LFSR stuck at 0xFF (XNOR lock-up) still terminates: the MAX_RETRY-th sample is accepted and gives next_type=0.
- The LFSR only advances when lfsr_step=1. The controller never asserts it in IDLE.
- Reset mid-refill abandons the draw. No ack is issued, and the initial fill restarts after rst falls.

Test Plan:
1. Real LFSR attached (reset 0x00, XNOR taps 7/3), release rst. First sample 0x01 → next_type=1, ready=1 after 2 cycles. Req → ack with piece_type=1; refill samples 0x03 → next_type=3.
2. Continue from 1: req → piece_type=3. Samples 0x07 and 0x0F are rejected; 0x1E is accepted → next_type=6, ready after 6 cycles. Req → piece_type=6, sample 0x3C → next_type=4.
3. Bench model holds lfsr_val=0xFF, MAX_RETRY=4 → exactly 4 lfsr_step pulses, next_type=0, ready=1 on the cycle after the 4th sample.
4. Duplicate rule: piece_type=2, bench returns 0x02 then 0x02 → first sample rejected, second accepted → next_type=2, 2 step pulses.
5. Hold piece_req high continuously from reset → no ack before the first ready. Acks are then spaced ≥3 cycles apart, one ack per IDLE entry, and lfsr_step is never high in IDLE.
6. Assert rst during FILL_SAMPLE of a refill → outputs return to reset values immediately, no ack. After release, the initial fill repeats from FILL_STEP.
